// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a REQ/BUSY/ACK load/store controller.
// Loads also drive the register-file write-back port.
module data_mem_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              MEM_WR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [2:0]        DEST,
    output logic              BUSY,
    output logic              ACK,
    output logic              ERR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              REG_WR,
    output logic [2:0]        REG_DEST,
    output logic [DATA_W-1:0] WRITE_DATA
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_ctrl: LATENCY must be >= 1");
    end

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("data_mem_ctrl: DEPTH must be in 1..2**ADDR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_dest;

    logic              r_busy;
    logic              r_ack;
    logic              r_err;
    logic              r_reg_wr;
    logic [DATA_W-1:0] r_rd;
    logic [2:0]        r_reg_dest;
    logic [DATA_W-1:0] r_wb;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_load_val;
    logic              w_commit;

    assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_load_val = w_in_range ? r_mem[w_idx] : '0;
    assign w_commit   = (r_state == S_WAIT) && (r_cnt == '0);

    // Array is deliberately left out of reset; an aborted store never lands.
    always_ff @(posedge CLK) begin
        if (!RESET && w_commit && r_wr && w_in_range) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dest     <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_rd       <= '0;
            r_reg_dest <= '0;
            r_wb       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_reg_wr <= 1'b0;
                    if (REQ) begin
                        r_wr    <= MEM_WR;
                        r_addr  <= ADDR;
                        r_wdata <= WR_DATA;
                        r_dest  <= DEST;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_RESP;
                        r_ack    <= 1'b1;
                        r_err    <= !w_in_range;
                        r_reg_wr <= !r_wr;
                        if (!r_wr) begin
                            r_rd       <= w_load_val;
                            r_wb       <= w_load_val;
                            r_reg_dest <= r_dest;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_reg_wr <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY       = r_busy;
    assign ACK        = r_ack;
    assign ERR        = r_err;
    assign RD_DATA    = r_rd;
    assign REG_WR     = r_reg_wr;
    assign REG_DEST   = r_reg_dest;
    assign WRITE_DATA = r_wb;

endmodule
